// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hdmi_pkg
// Purpose : Shared types and constants for the HDMI timing controller:
//           the transmitter period encoding, coordinate width and the
//           preamble/guard-band lengths used ahead of each video line.
// Rev     : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  localparam int COORD_W      = 12;
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

  typedef enum logic [1:0] {
    P_CONTROL  = 2'd0,
    P_PREAMBLE = 2'd1,
    P_GUARD    = 2'd2,
    P_VIDEO    = 2'd3
  } period_t;

endpackage
`default_nettype wire

// File: rtl/hdmi_line_counter.sv
`default_nettype none
// ============================================================================
// Module  : hdmi_line_counter
// Purpose : Wrapping position counter. Counts 0..LAST when en is high and
//           wraps to 0; reset loads RST_VAL.
// Ports   : clk, rst (async, active-high), en (advance),
//           count (registered value), count_next (value after this cycle),
//           tc (count is at LAST; an advance now wraps)
// Rev     : 1.0 - initial release
// ============================================================================
module hdmi_line_counter
  import hdmi_pkg::*;
#(
  parameter int LAST    = 799,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               tc
);

  localparam logic [COORD_W-1:0] c_last = COORD_W'(LAST);
  localparam logic [COORD_W-1:0] c_rst  = COORD_W'(RST_VAL);
  localparam logic [COORD_W-1:0] c_one  = COORD_W'(1);

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] w_next;

  assign tc = (r_count == c_last);

  always_comb begin
    w_next = r_count;
    if (en) begin
      w_next = tc ? '0 : (r_count + c_one);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_rst;
    end else begin
      r_count <= w_next;
    end
  end

  assign count      = r_count;
  assign count_next = w_next;

endmodule
`default_nettype wire

// File: rtl/hdmi_timing_controller.sv
`default_nettype none
// ============================================================================
// Module  : hdmi_timing_controller
// Purpose : Video raster timing generator for an HDMI transmitter. Produces
//           x/y position, hsync/vsync, de, a one-pixel-early pixel_req,
//           line/frame start pulses and the transmitter period/ctl code.
//           Every output is registered and decoded from the position the
//           counters are moving to, so outputs always match the current x/y.
// Ports   : clk, rst (async, active-high), en (advance one pixel),
//           x, y, hsync, vsync, de, pixel_req, frame_start, line_start,
//           period (0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 VIDEO), ctl
// Config  : HDMI_TIMING_PREAMBLE_EN - when defined, an 8-pixel preamble and
//           2-pixel guard band precede every active line; otherwise period
//           is only CONTROL/VIDEO and ctl is constant zero.
// Rev     : 1.0 - initial release
// ============================================================================
module hdmi_timing_controller
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pixel_req,
  output logic               frame_start,
  output logic               line_start,
  output logic [1:0]         period,
  output logic [3:0]         ctl
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Preamble+guard must fit in horizontal blanking, and the reset line
  // (V_ACTIVE) must be a blanking line.
  generate
    if ((H_FP + H_SYNC + H_BP) < (PREAMBLE_LEN + GUARD_LEN) || V_FP < 1) begin : g_param_check
      $error("hdmi_timing_controller: blanking too short for preamble/guard or V_FP < 1");
    end
  endgenerate

  localparam logic [COORD_W-1:0] c_h_active   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_h_act_last = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] c_h_last     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_hs_start   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] c_hs_end     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] c_v_active   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_last     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_vs_start   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] c_vs_end     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] c_one        = COORD_W'(1);
  localparam logic               c_sync_on    = (SYNC_POL != 0);

  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic [COORD_W-1:0] w_y_succ;
  logic               w_x_tc;
  logic               w_y_tc;
  logic               w_de_next;
  logic               w_hs_next;
  logic               w_vs_next;
  logic               w_succ_active;
  logic               w_preq_next;

  hdmi_line_counter #(.LAST(H_TOTAL - 1), .RST_VAL(0)) u_x_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count      (x),
    .count_next (w_x_next),
    .tc         (w_x_tc)
  );

  hdmi_line_counter #(.LAST(V_TOTAL - 1), .RST_VAL(V_ACTIVE)) u_y_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en & w_x_tc),
    .count      (y),
    .count_next (w_y_next),
    .tc         (w_y_tc)
  );

  // Decode of the position the counters will hold after this cycle.
  always_comb begin
    w_de_next     = (w_x_next < c_h_active) && (w_y_next < c_v_active);
    w_hs_next     = (w_x_next >= c_hs_start) && (w_x_next < c_hs_end);
    w_vs_next     = (w_y_next >= c_vs_start) && (w_y_next < c_vs_end);
    w_y_succ      = (w_y_next == c_v_last) ? '0 : (w_y_next + c_one);
    w_succ_active = (w_y_succ < c_v_active);
    // pixel_req looks one pixel ahead: either the next pixel on this line is
    // active, or we sit on the last column and the following line is active.
    w_preq_next   = ((w_x_next < c_h_act_last) && (w_y_next < c_v_active)) ||
                    ((w_x_next == c_h_last) && w_succ_active);
  end

  logic r_de, r_hsync, r_vsync, r_preq, r_fs, r_ls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de    <= 1'b0;
      r_hsync <= ~c_sync_on;
      r_vsync <= ~c_sync_on;
      r_preq  <= 1'b0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
    end else begin
      r_fs <= en & w_x_tc & w_y_tc;
      r_ls <= en & w_x_tc;
      if (en) begin
        r_de    <= w_de_next;
        r_hsync <= w_hs_next ? c_sync_on : ~c_sync_on;
        r_vsync <= w_vs_next ? c_sync_on : ~c_sync_on;
        r_preq  <= w_preq_next;
      end
    end
  end

  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign pixel_req   = r_preq;
  assign frame_start = r_fs;
  assign line_start  = r_ls;

  // Period FSM
  period_t r_period;
  period_t w_period_next;

`ifdef HDMI_TIMING_PREAMBLE_EN
  localparam logic [COORD_W-1:0] c_pre_start   = COORD_W'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [COORD_W-1:0] c_guard_start = COORD_W'(H_TOTAL - GUARD_LEN);

  always_comb begin
    w_period_next = r_period;
    if (en) begin
      case (r_period)
        P_CONTROL: begin
          if (w_de_next)                                       w_period_next = P_VIDEO;
          else if ((w_x_next == c_pre_start) && w_succ_active) w_period_next = P_PREAMBLE;
        end
        P_PREAMBLE: if (w_x_next == c_guard_start) w_period_next = P_GUARD;
        P_GUARD:    if (w_x_next == '0) w_period_next = w_de_next ? P_VIDEO : P_CONTROL;
        P_VIDEO:    if (!w_de_next) w_period_next = P_CONTROL;
        default:    w_period_next = P_CONTROL;
      endcase
    end
  end

  logic [3:0] r_ctl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl <= 4'b0000;
    end else begin
      r_ctl <= (w_period_next == P_PREAMBLE) ? CTL_VIDEO_PREAMBLE : 4'b0000;
    end
  end

  assign ctl = r_ctl;
`else
  always_comb begin
    w_period_next = r_period;
    if (en) begin
      w_period_next = w_de_next ? P_VIDEO : P_CONTROL;
    end
  end

  assign ctl = 4'b0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= P_CONTROL;
    end else begin
      r_period <= w_period_next;
    end
  end

  assign period = r_period;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdmi_timing_controller
// Purpose : Directed self-checking bench for hdmi_timing_controller at the
//           default 640x480 timing, with a position-based reference model
//           tracked every cycle.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_hdmi_timing_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] x, y;
  logic        hsync, vsync, de, pixel_req, frame_start, line_start;
  logic [1:0]  period;
  logic [3:0]  ctl;

  always #5 clk = ~clk;

  hdmi_timing_controller dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pixel_req   (pixel_req),
    .frame_start (frame_start),
    .line_start  (line_start),
    .period      (period),
    .ctl         (ctl)
  );

`ifdef HDMI_TIMING_PREAMBLE_EN
  localparam int EXP_PRE   = 1;
  localparam int EXP_GUARD = 2;
`else
  localparam int EXP_PRE   = 0;
  localparam int EXP_GUARD = 0;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  int trace_errs   = 0;
  int de_cnt       = 0;
  int video_seen   = 0;
  int mx, my;
  bit m_ls, m_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_de(input int px, input int py);
    return (px < 640) && (py < 480);
  endfunction

  function automatic int exp_period(input int px, input int py);
    int succ;
    if (m_de(px, py)) return 3;
    succ = (py == 524) ? 0 : py + 1;
    if (succ < 480 && px >= 790 && px <= 797) return EXP_PRE;
    if (succ < 480 && px >= 798) return EXP_GUARD;
    return 0;
  endfunction

  function automatic bit exp_preq(input int px, input int py);
    int nx, ny;
    nx = (px == 799) ? 0 : px + 1;
    ny = (px == 799) ? ((py == 524) ? 0 : py + 1) : py;
    return m_de(nx, ny);
  endfunction

  // One clock; advance the model if en was high, compare everything.
  task automatic tick();
    bit adv;
    int ep;
    adv = en;
    @(posedge clk);
    #1;
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (adv) begin
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      m_ls = (mx == 0);
      m_fs = (mx == 0) && (my == 0);
    end
    ep = exp_period(mx, my);
    if (x !== 12'(mx) || y !== 12'(my) || de !== m_de(mx, my) ||
        hsync !== !(mx >= 656 && mx < 752) || vsync !== !(my >= 490 && my < 492) ||
        pixel_req !== exp_preq(mx, my) || line_start !== m_ls || frame_start !== m_fs ||
        period !== 2'(ep) || ctl !== ((ep == 1) ? 4'b0001 : 4'b0000))
      trace_errs++;
    if (de === 1'b1) de_cnt++;
    if (period === 2'd3) video_seen++;
  endtask

  task automatic run_to(input int tx, input int ty);
    int budget;
    budget = 0;
    while (!(mx == tx && my == ty) && budget < 50000) begin
      tick();
      budget++;
    end
    if (!(mx == tx && my == ty)) check("run_to_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 480);
    check("rst_de", 32'(de), 0);
    check("rst_preq", 32'(pixel_req), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_period", 32'(period), 0);
    check("rst_ctl", 32'(ctl), 0);
    check("rst_pulses", 32'({frame_start, line_start}), 0);

    rst = 1'b0;
    en  = 1'b1;
    mx  = 0;
    my  = 480;
    tick();
    check("first_adv_x", 32'(x), 1);
    check("first_adv_y", 32'(y), 480);

    // Freeze with en low
    run_to(100, 481);
    en = 1'b0;
    repeat (5) tick();
    check("freeze_x", 32'(x), 100);
    check("freeze_ls", 32'(line_start), 0);
    en = 1'b1;
    tick();
    check("resume_x", 32'(x), 101);

    // hsync edges
    run_to(655, 481);
    check("hs_655", 32'(hsync), 1);
    tick();
    check("hs_656", 32'(hsync), 0);
    run_to(751, 481);
    check("hs_751", 32'(hsync), 0);
    tick();
    check("hs_752", 32'(hsync), 1);

    // vsync lines
    run_to(0, 489);
    check("vs_489", 32'(vsync), 1);
    run_to(0, 490);
    check("vs_490", 32'(vsync), 0);
    run_to(799, 491);
    check("vs_491", 32'(vsync), 0);
    tick();
    check("vs_492", 32'(vsync), 1);

    // Frame wrap
    run_to(799, 524);
    check("preq_wrap", 32'(pixel_req), 1);
    check("de_799_524", 32'(de), 0);
    tick();
    check("fs_00", 32'(frame_start), 1);
    check("ls_00", 32'(line_start), 1);
    check("de_00", 32'(de), 1);
    de_cnt = 0;

    // Preamble/guard ahead of line 10
    run_to(789, 9);
    check("period_789_9", 32'(period), 0);
    tick();
    check("period_790_9", 32'(period), 32'(EXP_PRE));
    check("ctl_790_9", 32'(ctl), (EXP_PRE == 1) ? 32'd1 : 32'd0);
    run_to(797, 9);
    check("period_797_9", 32'(period), 32'(EXP_PRE));
    tick();
    check("period_798_9", 32'(period), 32'(EXP_GUARD));
    check("ctl_798_9", 32'(ctl), 0);
    tick();
    check("preq_799_9", 32'(pixel_req), 1);
    tick();
    check("period_0_10", 32'(period), 3);
    check("de_lines_0_9", 32'(de_cnt), 6400);

    // Asynchronous reset mid-line (inside the preamble when enabled)
    run_to(792, 20);
    rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 480);
    check("arst_period", 32'(period), 0);
    check("arst_hsync", 32'(hsync), 1);
    check("arst_de", 32'(de), 0);
    check("arst_ctl", 32'(ctl), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mx  = 0;
    my  = 480;
    video_seen = 0;
    tick();
    check("post_rst_x", 32'(x), 1);
    check("post_rst_y", 32'(y), 480);
    run_to(0, 490);
    check("no_video_after_rst", 32'(video_seen), 0);

    check("trace_errs", 32'(trace_errs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
